// File: rtl/reg_cr_pkg.sv
// reg_cr_pkg: shared sizes, CR permission bits and entry/write types for the capability register file
package reg_cr_pkg;
   localparam int SIZE_ADDR   = 16;
   localparam int SIZE_DATA   = 8;
   localparam int SIZE_TGT_CR = 3;
   localparam int SIZE_TGT_AR = 3;
   localparam int HBIT_ADDR   = SIZE_ADDR - 1;
   localparam int HBIT_DATA   = SIZE_DATA - 1;
   localparam int HBIT_TGT_CR = SIZE_TGT_CR - 1;
   localparam int HBIT_TGT_AR = SIZE_TGT_AR - 1;
   localparam int NUM_CR      = 1 << SIZE_TGT_CR;
   localparam int PERM_LOAD   = 0;
   localparam int PERM_STORE  = 1;
   localparam int PERM_EXEC   = 2;

   typedef struct packed {
      logic [HBIT_ADDR:0] base;
      logic [HBIT_ADDR:0] len;
      logic [HBIT_ADDR:0] cur;
      logic [HBIT_DATA:0] perms;
      logic [HBIT_DATA:0] attr;
      logic               tag;
   } cr_entry_t;

   typedef struct packed {
      logic we_base, we_len, we_cur, we_perms, we_attr, we_tag;
      cr_entry_t data;
   } cr_wr_t;

   // Post-write view of one entry: CR-path cur beats AR-path cur; bounds/perm edits drop the tag unless it is written.
   function automatic cr_entry_t cr_merge(cr_entry_t old, logic cr_hit, cr_wr_t wr, logic ar_hit,
                                          logic [HBIT_ADDR:0] ar_data);
      cr_entry_t n;
      n.base  = cr_hit && wr.we_base  ? wr.data.base  : old.base;
      n.len   = cr_hit && wr.we_len   ? wr.data.len   : old.len;
      n.perms = cr_hit && wr.we_perms ? wr.data.perms : old.perms;
      n.attr  = cr_hit && wr.we_attr  ? wr.data.attr  : old.attr;
      n.cur   = cr_hit && wr.we_cur   ? wr.data.cur   : ar_hit ? ar_data : old.cur;
      n.tag   = cr_hit && wr.we_tag   ? wr.data.tag   :
                cr_hit && (wr.we_base || wr.we_len || wr.we_perms || wr.we_attr) ? 1'b0 : old.tag;
      return n;
   endfunction
endpackage

// File: rtl/reg_cr_rd_bypass.sv
// cr_rd_bypass: one read port with zero-cycle write-through and in-bounds flag
module cr_rd_bypass
   import reg_cr_pkg::*;
(
   input  logic [HBIT_TGT_CR:0] rd_addr,
   input  cr_entry_t            stored,
   input  logic [HBIT_TGT_CR:0] cr_addr,
   input  cr_wr_t               wr,
   input  logic                 ar_we,
   input  logic [HBIT_TGT_AR:0] ar_addr,
   input  logic [HBIT_ADDR:0]   ar_data,
   output cr_entry_t            rd,
   output logic                 inb
);
   logic [SIZE_ADDR:0] lim;
   always_comb begin
      rd  = cr_merge(stored, cr_addr == rd_addr, wr, ar_we && SIZE_TGT_CR'(ar_addr) == rd_addr, ar_data);
      lim = {1'b0, rd.base} + {1'b0, rd.len};
      inb = rd.tag && rd.cur >= rd.base && {1'b0, rd.cur} < lim;
   end
endmodule

// File: rtl/reg_cr.sv
// reg_cr: capability register file with per-field writes, AR-path cur updates and two bypassed read ports
module reg_cr
   import reg_cr_pkg::*;
(
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic [HBIT_TGT_CR:0] iw_cr_write_addr,
   input  logic                 iw_cr_we_base,
   input  logic                 iw_cr_we_len,
   input  logic                 iw_cr_we_cur,
   input  logic [HBIT_ADDR:0]   iw_cr_base,
   input  logic [HBIT_ADDR:0]   iw_cr_len,
   input  logic [HBIT_ADDR:0]   iw_cr_cur,
   input  logic                 iw_cr_we_perms,
   input  logic                 iw_cr_we_attr,
   input  logic [HBIT_DATA:0]   iw_cr_perms,
   input  logic [HBIT_DATA:0]   iw_cr_attr,
   input  logic                 iw_cr_we_tag,
   input  logic                 iw_cr_tag,
   input  logic                 iw_ar_write_enable,
   input  logic [HBIT_TGT_AR:0] iw_ar_write_addr,
   input  logic [HBIT_ADDR:0]   iw_ar_write_data,
   input  logic [HBIT_TGT_CR:0] iw_r0_addr,
   output logic [HBIT_ADDR:0]   ow_r0_base,
   output logic [HBIT_ADDR:0]   ow_r0_len,
   output logic [HBIT_ADDR:0]   ow_r0_cur,
   output logic [HBIT_DATA:0]   ow_r0_perms,
   output logic [HBIT_DATA:0]   ow_r0_attr,
   output logic                 ow_r0_tag,
   output logic                 ow_r0_inb,
   input  logic [HBIT_TGT_CR:0] iw_r1_addr,
   output logic [HBIT_ADDR:0]   ow_r1_base,
   output logic [HBIT_ADDR:0]   ow_r1_len,
   output logic [HBIT_ADDR:0]   ow_r1_cur,
   output logic [HBIT_DATA:0]   ow_r1_perms,
   output logic [HBIT_DATA:0]   ow_r1_attr,
   output logic                 ow_r1_tag,
   output logic                 ow_r1_inb
);
   cr_entry_t mem [NUM_CR];
   cr_wr_t    wr;
   logic      ar_we;
   cr_entry_t rd0, rd1;

   // Writes are masked during reset so the bypass cannot leak them onto the read ports.
   always_comb begin
      wr.we_base  = iw_cr_we_base  && !iw_rst;
      wr.we_len   = iw_cr_we_len   && !iw_rst;
      wr.we_cur   = iw_cr_we_cur   && !iw_rst;
      wr.we_perms = iw_cr_we_perms && !iw_rst;
      wr.we_attr  = iw_cr_we_attr  && !iw_rst;
      wr.we_tag   = iw_cr_we_tag   && !iw_rst;
      wr.data     = '{base: iw_cr_base, len: iw_cr_len, cur: iw_cr_cur,
                      perms: iw_cr_perms, attr: iw_cr_attr, tag: iw_cr_tag};
      ar_we       = iw_ar_write_enable && !iw_rst;
   end

   always_ff @(posedge iw_clk or posedge iw_rst)
      if (iw_rst)
         for (int i = 0; i < NUM_CR; i++) mem[i] <= '0;
      else
         for (int i = 0; i < NUM_CR; i++)
            mem[i] <= cr_merge(mem[i], iw_cr_write_addr == SIZE_TGT_CR'(i), wr,
                               ar_we && iw_ar_write_addr == SIZE_TGT_AR'(i), iw_ar_write_data);

   cr_rd_bypass u_rd0 (
      .rd_addr (iw_r0_addr),
      .stored  (mem[iw_r0_addr]),
      .cr_addr (iw_cr_write_addr),
      .wr      (wr),
      .ar_we   (ar_we),
      .ar_addr (iw_ar_write_addr),
      .ar_data (iw_ar_write_data),
      .rd      (rd0),
      .inb     (ow_r0_inb)
   );

   cr_rd_bypass u_rd1 (
      .rd_addr (iw_r1_addr),
      .stored  (mem[iw_r1_addr]),
      .cr_addr (iw_cr_write_addr),
      .wr      (wr),
      .ar_we   (ar_we),
      .ar_addr (iw_ar_write_addr),
      .ar_data (iw_ar_write_data),
      .rd      (rd1),
      .inb     (ow_r1_inb)
   );

   assign {ow_r0_base, ow_r0_len, ow_r0_cur, ow_r0_perms, ow_r0_attr, ow_r0_tag} = rd0;
   assign {ow_r1_base, ow_r1_len, ow_r1_cur, ow_r1_perms, ow_r1_attr, ow_r1_tag} = rd1;
endmodule

// File: tb/tb_reg_cr.sv
// tb_reg_cr: randomized and directed checks of reg_cr against an array-based reference model
module tb_reg_cr;
   import reg_cr_pkg::*;

   typedef struct packed {
      logic [15:0] base, len, cur;
      logic [7:0]  perms, attr;
      logic        tag, inb;
   } view_t;

   logic        iw_clk = 0, iw_rst = 1;
   logic [2:0]  iw_cr_write_addr;
   logic        iw_cr_we_base, iw_cr_we_len, iw_cr_we_cur, iw_cr_we_perms, iw_cr_we_attr, iw_cr_we_tag, iw_cr_tag;
   logic [15:0] iw_cr_base, iw_cr_len, iw_cr_cur;
   logic [7:0]  iw_cr_perms, iw_cr_attr;
   logic        iw_ar_write_enable;
   logic [2:0]  iw_ar_write_addr;
   logic [15:0] iw_ar_write_data;
   logic [2:0]  iw_r0_addr, iw_r1_addr;
   logic [15:0] ow_r0_base, ow_r0_len, ow_r0_cur, ow_r1_base, ow_r1_len, ow_r1_cur;
   logic [7:0]  ow_r0_perms, ow_r0_attr, ow_r1_perms, ow_r1_attr;
   logic        ow_r0_tag, ow_r0_inb, ow_r1_tag, ow_r1_inb;

   int checks = 0, errors = 0;
   int m_base [8], m_len [8], m_cur [8], m_perms [8], m_attr [8], m_tag [8];

   reg_cr dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_cr_write_addr(iw_cr_write_addr),
      .iw_cr_we_base(iw_cr_we_base), .iw_cr_we_len(iw_cr_we_len), .iw_cr_we_cur(iw_cr_we_cur),
      .iw_cr_base(iw_cr_base), .iw_cr_len(iw_cr_len), .iw_cr_cur(iw_cr_cur),
      .iw_cr_we_perms(iw_cr_we_perms), .iw_cr_we_attr(iw_cr_we_attr),
      .iw_cr_perms(iw_cr_perms), .iw_cr_attr(iw_cr_attr),
      .iw_cr_we_tag(iw_cr_we_tag), .iw_cr_tag(iw_cr_tag),
      .iw_ar_write_enable(iw_ar_write_enable), .iw_ar_write_addr(iw_ar_write_addr),
      .iw_ar_write_data(iw_ar_write_data),
      .iw_r0_addr(iw_r0_addr), .ow_r0_base(ow_r0_base), .ow_r0_len(ow_r0_len), .ow_r0_cur(ow_r0_cur),
      .ow_r0_perms(ow_r0_perms), .ow_r0_attr(ow_r0_attr), .ow_r0_tag(ow_r0_tag), .ow_r0_inb(ow_r0_inb),
      .iw_r1_addr(iw_r1_addr), .ow_r1_base(ow_r1_base), .ow_r1_len(ow_r1_len), .ow_r1_cur(ow_r1_cur),
      .ow_r1_perms(ow_r1_perms), .ow_r1_attr(ow_r1_attr), .ow_r1_tag(ow_r1_tag), .ow_r1_inb(ow_r1_inb)
   );

   always #5 iw_clk = ~iw_clk;

   function automatic view_t dut_v0();
      return {ow_r0_base, ow_r0_len, ow_r0_cur, ow_r0_perms, ow_r0_attr, ow_r0_tag, ow_r0_inb};
   endfunction

   function automatic view_t dut_v1();
      return {ow_r1_base, ow_r1_len, ow_r1_cur, ow_r1_perms, ow_r1_attr, ow_r1_tag, ow_r1_inb};
   endfunction

   // What entry a should look like once the currently driven writes land.
   function automatic view_t exp_v(int a);
      int b, l, c, p, t, at;
      bit cr_hit, any_meta;
      view_t v;
      if (iw_rst) return '0;
      b = m_base[a]; l = m_len[a]; c = m_cur[a]; p = m_perms[a]; at = m_attr[a]; t = m_tag[a];
      cr_hit = int'(iw_cr_write_addr) == a;
      any_meta = iw_cr_we_base || iw_cr_we_len || iw_cr_we_perms || iw_cr_we_attr;
      if (iw_ar_write_enable && int'(iw_ar_write_addr) == a) c = int'(iw_ar_write_data);
      if (cr_hit) begin
         if (iw_cr_we_base)  b = int'(iw_cr_base);
         if (iw_cr_we_len)   l = int'(iw_cr_len);
         if (iw_cr_we_cur)   c = int'(iw_cr_cur);
         if (iw_cr_we_perms) p = int'(iw_cr_perms);
         if (iw_cr_we_attr)  at = int'(iw_cr_attr);
         if (iw_cr_we_tag) t = int'(iw_cr_tag);
         else if (any_meta) t = 0;
      end
      v.base = 16'(b); v.len = 16'(l); v.cur = 16'(c); v.perms = 8'(p); v.attr = 8'(at);
      v.tag = t != 0;
      v.inb = t != 0 && l > 0 && c >= b && c < b + l;
      return v;
   endfunction

   task automatic model_clear();
      for (int a = 0; a < 8; a++) begin
         m_base[a] = 0; m_len[a] = 0; m_cur[a] = 0; m_perms[a] = 0; m_attr[a] = 0; m_tag[a] = 0;
      end
   endtask

   task automatic tick();
      view_t nv [8];
      @(posedge iw_clk);
      for (int a = 0; a < 8; a++) nv[a] = exp_v(a);
      for (int a = 0; a < 8; a++) begin
         m_base[a] = int'(nv[a].base); m_len[a] = int'(nv[a].len); m_cur[a] = int'(nv[a].cur);
         m_perms[a] = int'(nv[a].perms); m_attr[a] = int'(nv[a].attr); m_tag[a] = int'(nv[a].tag);
      end
   endtask

   task automatic idle();
      iw_cr_we_base = 0; iw_cr_we_len = 0; iw_cr_we_cur = 0; iw_cr_we_perms = 0; iw_cr_we_attr = 0;
      iw_cr_we_tag = 0; iw_cr_tag = 0; iw_ar_write_enable = 0; iw_cr_write_addr = 0; iw_ar_write_addr = 0;
      iw_cr_base = 0; iw_cr_len = 0; iw_cr_cur = 0; iw_cr_perms = 0; iw_cr_attr = 0; iw_ar_write_data = 0;
   endtask

   task automatic test_reset();
      idle(); iw_rst = 1; iw_r0_addr = 2; iw_r1_addr = 5; model_clear();
      repeat (2) @(posedge iw_clk);
      @(negedge iw_clk); iw_rst = 0; #2;
      checks++;
      if (dut_v0() !== view_t'(0)) begin errors++; $display("FAIL reset_r0_cr2 got %h exp 0", dut_v0()); end
      for (int a = 0; a < 8; a++) begin
         iw_r1_addr = 3'(a); #1;
         checks++;
         if (dut_v1() !== view_t'(0)) begin errors++; $display("FAIL reset_r1_cr%0d got %h exp 0", a, dut_v1()); end
      end
   endtask

   task automatic test_write_through();
      view_t v;
      @(negedge iw_clk); idle(); iw_r0_addr = 2; iw_r1_addr = 2;
      iw_cr_write_addr = 2; iw_cr_we_base = 1; iw_cr_we_len = 1; iw_cr_we_cur = 1; iw_cr_we_tag = 1;
      iw_cr_base = 100; iw_cr_len = 50; iw_cr_cur = 120; iw_cr_tag = 1;
      iw_cr_we_perms = 1; iw_cr_perms = 8'((1 << PERM_LOAD) | (1 << PERM_STORE) | (1 << PERM_EXEC));
      #2; v = dut_v0();
      checks++;
      if (v !== exp_v(2)) begin errors++; $display("FAIL bypass_cr2 got %h exp %h", v, exp_v(2)); end
      checks++;
      if ({v.base, v.len, v.cur, v.tag, v.inb} !== {16'd100, 16'd50, 16'd120, 1'b1, 1'b1})
         begin errors++; $display("FAIL bypass_cr2_const got %h", v); end
      tick();
      @(negedge iw_clk); idle(); #2;
      checks++;
      if (ow_r0_inb !== 1'b1 || dut_v0() !== exp_v(2)) begin errors++; $display("FAIL stored_cr2 got %h exp %h", dut_v0(), exp_v(2)); end
      iw_cr_write_addr = 2; iw_cr_we_len = 1; iw_cr_len = 10; #2; v = dut_v0();
      checks++;
      if ({v.base, v.len, v.cur, v.tag, v.inb} !== {16'd100, 16'd10, 16'd120, 1'b0, 1'b0})
         begin errors++; $display("FAIL len_write_bypass got %h", v); end
      tick();
      @(negedge iw_clk); idle(); #2; v = dut_v0();
      checks++;
      if ({v.base, v.len, v.cur, v.tag, v.inb} !== {16'd100, 16'd10, 16'd120, 1'b0, 1'b0} || v !== exp_v(2))
         begin errors++; $display("FAIL len_write_stored got %h exp %h", v, exp_v(2)); end
   endtask

   task automatic test_priority();
      @(negedge iw_clk); idle(); iw_r0_addr = 1; iw_r1_addr = 1;
      iw_cr_write_addr = 1; iw_cr_we_cur = 1; iw_cr_cur = 7;
      iw_ar_write_enable = 1; iw_ar_write_addr = 1; iw_ar_write_data = 9; #2;
      checks++;
      if (ow_r0_cur !== 16'd7 || dut_v1() !== dut_v0()) begin errors++; $display("FAIL prio_bypass got r0 %h r1 %h exp cur 7", dut_v0(), dut_v1()); end
      tick();
      @(negedge iw_clk); idle(); #2;
      checks++;
      if (ow_r0_cur !== 16'd7 || ow_r1_cur !== 16'd7 || dut_v0() !== exp_v(1))
         begin errors++; $display("FAIL prio_stored got r0 %h r1 %h exp %h", dut_v0(), dut_v1(), exp_v(1)); end
   endtask

   task automatic test_boundary();
      @(negedge iw_clk); idle(); iw_r0_addr = 3; iw_r1_addr = 0;
      iw_cr_write_addr = 3; iw_cr_we_base = 1; iw_cr_we_len = 1; iw_cr_we_cur = 1; iw_cr_we_tag = 1;
      iw_cr_base = 16'hFFFC; iw_cr_len = 8; iw_cr_cur = 16'hFFFF; iw_cr_tag = 1;
      tick();
      @(negedge iw_clk); idle(); #2;
      checks++;
      if (ow_r0_inb !== 1'b1 || dut_v0() !== exp_v(3)) begin errors++; $display("FAIL top_nowrap got %h exp %h", dut_v0(), exp_v(3)); end
      iw_ar_write_enable = 1; iw_ar_write_addr = 3; iw_ar_write_data = 0;
      tick();
      @(negedge iw_clk); idle(); #2;
      checks++;
      if (ow_r0_inb !== 1'b0 || ow_r0_tag !== 1'b1 || dut_v0() !== exp_v(3))
         begin errors++; $display("FAIL ar_cur_zero got %h exp %h", dut_v0(), exp_v(3)); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         @(negedge iw_clk);
         iw_cr_write_addr = 3'($urandom_range(0, 7));
         iw_cr_we_base = $urandom_range(0, 3) == 0; iw_cr_we_len = $urandom_range(0, 3) == 0;
         iw_cr_we_cur = $urandom_range(0, 2) == 0; iw_cr_we_perms = $urandom_range(0, 4) == 0;
         iw_cr_we_attr = $urandom_range(0, 4) == 0; iw_cr_we_tag = $urandom_range(0, 2) == 0;
         iw_cr_tag = $urandom_range(0, 3) != 0;
         iw_cr_base = n % 5 == 0 ? 16'($urandom) : 16'($urandom_range(0, 40));
         iw_cr_len = n % 7 == 0 ? 16'($urandom) : 16'($urandom_range(0, 20));
         iw_cr_cur = n % 5 == 1 ? 16'($urandom) : 16'($urandom_range(0, 64));
         iw_cr_perms = 8'($urandom); iw_cr_attr = 8'($urandom);
         iw_ar_write_enable = $urandom_range(0, 2) == 0; iw_ar_write_addr = 3'($urandom_range(0, 7));
         iw_ar_write_data = 16'($urandom_range(0, 64));
         iw_r0_addr = $urandom_range(0, 1) ? iw_cr_write_addr : 3'($urandom_range(0, 7));
         iw_r1_addr = $urandom_range(0, 1) ? iw_ar_write_addr : 3'($urandom_range(0, 7));
         #2;
         checks++;
         if (dut_v0() !== exp_v(int'(iw_r0_addr)) || dut_v1() !== exp_v(int'(iw_r1_addr)))
            begin errors++; $display("FAIL rand_%0d r0 got %h exp %h r1 got %h exp %h", n, dut_v0(), exp_v(int'(iw_r0_addr)), dut_v1(), exp_v(int'(iw_r1_addr))); end
         tick();
      end
   endtask

   task automatic test_async_reset();
      @(negedge iw_clk); idle(); iw_r0_addr = 0; iw_r1_addr = 0;
      iw_cr_write_addr = 0; iw_cr_we_base = 1; iw_cr_we_len = 1; iw_cr_we_cur = 1; iw_cr_we_tag = 1;
      iw_cr_base = 10; iw_cr_len = 10; iw_cr_cur = 12; iw_cr_tag = 1; #1;
      checks++;
      if (ow_r0_inb !== 1'b1) begin errors++; $display("FAIL pre_reset_inb got %b exp 1", ow_r0_inb); end
      iw_rst = 1; model_clear(); #1;
      checks++;
      if (dut_v0() !== view_t'(0)) begin errors++; $display("FAIL async_reset_out got %h exp 0", dut_v0()); end
      @(posedge iw_clk); @(negedge iw_clk); iw_rst = 0; idle(); #2;
      checks++;
      if (dut_v0() !== view_t'(0)) begin errors++; $display("FAIL cr0_after_reset got %h exp 0", dut_v0()); end
      for (int a = 1; a < 8; a++) begin
         iw_r1_addr = 3'(a); #1;
         checks++;
         if (dut_v1() !== view_t'(0)) begin errors++; $display("FAIL cleared_cr%0d got %h exp 0", a, dut_v1()); end
      end
   endtask

   initial begin
      test_reset();
      test_write_through();
      test_priority();
      test_boundary();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_cr.md
REG_CR -- requirements
Module: reg_cr

Interface
REQ-001 SHALL have these ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_cr_write_addr  in  SIZE_TGT_CR  CR index for field writes.
- iw_cr_we_base/len/cur  in  1 each  per-field write enables.
- iw_cr_base/len/cur  in  SIZE_ADDR each  field write data.
- iw_cr_we_perms/attr  in  1 each  per-field write enables.
- iw_cr_perms/attr  in  SIZE_DATA each  field write data.
- iw_cr_we_tag, iw_cr_tag  in  1, 1  tag write enable and tag data.
- iw_ar_write_enable, iw_ar_write_addr, iw_ar_write_data  in  1, SIZE_TGT_AR, SIZE_ADDR  AR-path update of cur.
- iw_rN_addr (N=0,1)  in  SIZE_TGT_CR  read-port index.
- ow_rN_base/len/cur  out  SIZE_ADDR each  read-port fields.
- ow_rN_perms/attr  out  SIZE_DATA each  read-port fields.
- ow_rN_tag  out  1  read-port tag.
- ow_rN_inb  out  1  tag && base <= cur < base+len.

Function
REQ-002 SHALL hold 2^SIZE_TGT_CR entries, each with base, len, cur, perms, attr, tag.
REQ-003 SHALL commit each enabled field to entry iw_cr_write_addr on the rising edge; disabled fields SHALL retain their value.
REQ-004 SHALL commit iw_ar_write_data to cur of entry iw_ar_write_addr on the rising edge when iw_ar_write_enable is high.
REQ-005 When the CR cur write and the AR write target the same entry in one cycle, SHALL commit the CR-path value.
REQ-006 When any of base/len/perms/attr is written without iw_cr_we_tag, SHALL clear that entry's tag to 0 (monotonicity). With iw_cr_we_tag, tag SHALL take iw_cr_tag.
REQ-007 Cur-only writes (either path) SHALL NOT change tag.
REQ-008 Read ports SHALL be combinational, with zero-cycle write-through: a field being written this cycle to the addressed entry SHALL appear on the outputs, using post-priority (REQ-005) and post-tag-rule (REQ-006) values.
REQ-009 ow_rN_inb SHALL be computed on the bypassed values. base+len SHALL be computed in SIZE_ADDR+1 bits (no wrap). len=0 SHALL give inb=0.
REQ-010 Both read ports addressing the same entry SHALL return identical values.
REQ-011 Out-of-range indices cannot occur, since the index width exactly covers the entry count.

Reset
REQ-012 On iw_rst, all fields of all entries SHALL become 0, including tag. All ow_rN_* SHALL then read 0 and inb SHALL be 0.
REQ-013 Writes presented while iw_rst is high SHALL be discarded. The first commit SHALL occur on the first rising edge after deassertion.
REQ-014 Reset asserted mid-operation SHALL override any same-cycle write.

Structure
REQ-015 SIZE_ADDR, SIZE_DATA, SIZE_TGT_CR, SIZE_TGT_AR and HBIT_* SHALL come from the shared sizes include. Field-permission bit constants SHALL come from the shared CR include.
REQ-016 The bypass/merge SHALL be one sub-module, cr_rd_bypass, instantiated once per read port. The storage SHALL stay in reg_cr.
REQ-017 The simulation-only write trace SHALL be excluded under SYNTHESIS.

Verification
REQ-018 Reset, then read entry 2 on r0 -> all fields 0, tag=0, inb=0.
REQ-019 One cycle writes CR2 base=100, len=50, cur=120, tag=1 (we_tag=1) -> same cycle r0 shows bypassed values with inb=1; next cycle still inb=1.
REQ-020 Then write CR2 len=10 without we_tag -> tag=0, inb=0, len=10, base and cur unchanged.
REQ-021 Same cycle: CR path cur=7 and AR path cur=9, both to CR1 -> CR1.cur=7 and is visible on r0 and r1 identically.
REQ-022 Write CR3 with base=2^SIZE_ADDR-4, len=8, cur=2^SIZE_ADDR-1, tag=1 -> inb=1 (no wrap). Then AR path cur=0 -> inb=0, tag still 1.
REQ-023 Assert iw_rst asynchronously mid-cycle during a CR0 write -> outputs go 0 immediately, and CR0 reads 0 after deassertion.
